main_module: RTL and testbench
==============================

MAIN_MODULE -- requirements
Module: main_module

Interface
REQ-001 The block SHALL run on one clock, TCK, with an asynchronous, active-high reset, TRST.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- TCK  in  1  test clock; the only clock
- TRST  in  1  async active-high reset
- TMS  in  1  mode select, sampled on TCK rising edge
- TDI  in  1  serial data in, sampled on TCK rising edge
- BIST_CLK  in  1  reserved; no logic uses it
- CORE_IN_1 / CORE_IN_2  in  1  core-side outputs to pins
- PIN_IN_1 / PIN_IN_2  in  1  pin-side inputs to core
- CORE_OUT_1 / CORE_OUT_2  out  1  values driven to the core
- PIN_OUT_1 / PIN_OUT_2  out  1  values driven to the pins
- TDO  out  1  serial data out
REQ-003 The block SHALL have the following parameters (name, default, meaning):
- IDCODE_VAL, 32'h1234_5679, device ID; bit 0 is 1
- IR_W, 4, instruction register width

Function
REQ-004 The TAP controller SHALL implement the 16 IEEE 1149.1 states, advancing on TCK rising edges per TMS, encoded as: TLR F, RTI C, SelDR 7, CapDR 6, ShiftDR 2, Exit1DR 1, PauseDR 3, Exit2DR 0, UpdDR 5, SelIR 4, CapIR E, ShiftIR A, Exit1IR 9, PauseIR B, Exit2IR 8, UpdIR D.
REQ-005 Five consecutive TCK rising edges with TMS=1 SHALL reach TLR from any state.
REQ-006 The instruction register SHALL behave as follows:
- CapIR loads 4'b0001 into the shift stage.
- ShiftIR shifts right: TDI enters bit 3, bit 0 drives TDO.
- The shifted value is copied to the active IR on the TCK falling edge in UpdIR.
REQ-007 Instruction decode SHALL be:
- BYPASS 4'hF
- SAMPLE_PRELOAD 4'h1
- IDCODE 4'h2
- EXTEST 4'h4
- INTEST 4'h8
- all other codes, including 4'h3/5/7/9, behave as BYPASS.
REQ-008 BYPASS SHALL select a 1-bit register that captures 0 in CapDR and gives a one-stage TDI-to-TDO path in ShiftDR.
REQ-009 IDCODE SHALL select a 32-bit register that loads IDCODE_VAL in CapDR and shifts it out LSB first.
REQ-010 The boundary scan register (BSR) SHALL have 4 cells, with TDI entering cell 3 and cell 0 driving TDO:
- cell 3 = PIN_IN_1
- cell 2 = PIN_IN_2
- cell 1 = PIN_OUT_1 (source CORE_IN_1)
- cell 0 = PIN_OUT_2 (source CORE_IN_2)
REQ-011 The BSR SHALL be selected by SAMPLE_PRELOAD, EXTEST and INTEST. In CapDR each cell captures its source: PIN_IN for input cells, CORE_IN for output cells.
REQ-012 The BSR shift stage SHALL be copied to a 4-bit update latch on the TCK falling edge in UpdDR; the latch SHALL hold its value in all other states.
REQ-013 The output muxes SHALL be combinational:
- Normal (BYPASS, IDCODE, SAMPLE_PRELOAD, others): PIN_OUT_x = CORE_IN_x; CORE_OUT_x = PIN_IN_x.
- EXTEST: PIN_OUT_1/2 = update cells 1/0; CORE_OUT_x = PIN_IN_x.
- INTEST: CORE_OUT_1/2 = update cells 3/2; PIN_OUT_1/2 = update cells 1/0.
REQ-014 TDO SHALL be registered on the TCK falling edge:
- ShiftIR: IR shift bit 0.
- ShiftDR: bit 0 of the selected data register.
- Otherwise: 0.
REQ-015 Shift registers SHALL hold their contents in the Pause and Exit states.
REQ-016 A new instruction SHALL take effect only after UpdIR; the output muxes SHALL switch immediately at that TCK falling edge.
REQ-017 Shifting more bits than a register's length SHALL leave the last-shifted bits in that register; excess bits pass out on TDO.

Reset
REQ-018 While TRST=1, asynchronously:
- TAP state = TLR
- active IR = IDCODE (4'h2)
- IR and DR shift stages = 0
- BSR update latch = 4'b0000
- TDO = 0
REQ-019 Outputs SHALL follow the normal-mode equations (REQ-013) during and after reset until a new instruction is updated.
REQ-020 Reset asserted mid-shift SHALL abort the shift without updating any latch.
REQ-021 Entering TLR via TMS SHALL also set the active IR to IDCODE and select normal mode; it SHALL NOT clear the update latch.

Verification
REQ-022 Pulse TRST=1 -> TDO=0; PIN_OUT_1/2 track CORE_IN_1/2; CORE_OUT_1/2 track PIN_IN_1/2.
REQ-023 After reset, go CapDR -> ShiftDR and shift 32 bits -> TDO yields 32'h1234_5679, LSB first.
REQ-024 Load IR 4'h4 (EXTEST), shift DR 13'h1E00 LSB first, pass UpdDR -> PIN_OUT_1=1, PIN_OUT_2=1 with CORE_IN=0; CORE_OUT_1/2 = PIN_IN_1/2.
REQ-025 Load IR 4'hF, shift pattern 1,0,1,1 -> TDO shows 0 (captured bypass bit), then the pattern delayed by one TCK.
REQ-026 ShiftIR immediately after CapIR -> first two TDO bits are 1 then 0.
REQ-027 Load INTEST with PIN_IN_1/2=1, shift BSR 4'b0000 -> CORE_OUT_1/2=0 after UpdDR; the first 4 TDO bits shifted out are 0,0,1,1 (captured cells 0..3).

Source files
------------

// File: rtl/main_module.sv
// main_module: IEEE 1149.1 TAP with IR, bypass, IDCODE and a 4-cell boundary scan register
module main_module #(
  parameter logic [31:0] IDCODE_VAL = 32'h1234_5679,
  parameter int          IR_W       = 4
) (
  input  logic TCK,
  input  logic TRST,
  input  logic TMS,
  input  logic TDI,
  input  logic BIST_CLK,
  input  logic CORE_IN_1,
  input  logic CORE_IN_2,
  input  logic PIN_IN_1,
  input  logic PIN_IN_2,
  output logic CORE_OUT_1,
  output logic CORE_OUT_2,
  output logic PIN_OUT_1,
  output logic PIN_OUT_2,
  output logic TDO
);
  typedef enum logic [3:0] {
    TLR = 4'hF, RTI = 4'hC, SEL_DR = 4'h7, CAP_DR = 4'h6, SHIFT_DR = 4'h2,
    EXIT1_DR = 4'h1, PAUSE_DR = 4'h3, EXIT2_DR = 4'h0, UPD_DR = 4'h5,
    SEL_IR = 4'h4, CAP_IR = 4'hE, SHIFT_IR = 4'hA, EXIT1_IR = 4'h9,
    PAUSE_IR = 4'hB, EXIT2_IR = 4'h8, UPD_IR = 4'hD
  } state_t;

  localparam logic [IR_W-1:0] OP_SAMPLE = IR_W'(1);
  localparam logic [IR_W-1:0] OP_IDCODE = IR_W'(2);
  localparam logic [IR_W-1:0] OP_EXTEST = IR_W'(4);
  localparam logic [IR_W-1:0] OP_INTEST = IR_W'(8);

  state_t state, next;
  logic [IR_W-1:0] ir_sr, ir;
  logic [31:0] id_sr;
  logic [3:0] bsr_sr, upd;
  logic bp_sr, sel_bsr, sel_id, sel_bp, drive_pins, drive_core, dr_bit;
  logic unused;

  assign unused = BIST_CLK;
  assign sel_bsr = ir == OP_SAMPLE || ir == OP_EXTEST || ir == OP_INTEST;
  assign sel_id = ir == OP_IDCODE;
  assign sel_bp = !sel_bsr && !sel_id;
  assign drive_pins = ir == OP_EXTEST || ir == OP_INTEST;
  assign drive_core = ir == OP_INTEST;
  assign dr_bit = sel_bsr ? bsr_sr[0] : sel_id ? id_sr[0] : bp_sr;

  // TAP state register
  always_ff @(posedge TCK or posedge TRST)
    if (TRST) state <= TLR;
    else state <= next;

  // TAP next-state decode from TMS
  always_comb begin
    next = TLR;
    case (state)
      TLR:      next = TMS ? TLR : RTI;
      RTI:      next = TMS ? SEL_DR : RTI;
      SEL_DR:   next = TMS ? SEL_IR : CAP_DR;
      CAP_DR:   next = TMS ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: next = TMS ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: next = TMS ? UPD_DR : PAUSE_DR;
      PAUSE_DR: next = TMS ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: next = TMS ? UPD_DR : SHIFT_DR;
      UPD_DR:   next = TMS ? SEL_DR : RTI;
      SEL_IR:   next = TMS ? TLR : CAP_IR;
      CAP_IR:   next = TMS ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: next = TMS ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: next = TMS ? UPD_IR : PAUSE_IR;
      PAUSE_IR: next = TMS ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: next = TMS ? UPD_IR : SHIFT_IR;
      UPD_IR:   next = TMS ? SEL_DR : RTI;
      default:  next = TLR;
    endcase
  end

  // Capture/shift stages; only the register picked by the active IR moves
  always_ff @(posedge TCK or posedge TRST)
    if (TRST) begin
      ir_sr <= '0;
      id_sr <= '0;
      bsr_sr <= '0;
      bp_sr <= 1'b0;
    end else begin
      ir_sr <= state == CAP_IR ? IR_W'(1) : state == SHIFT_IR ? {TDI, ir_sr[IR_W-1:1]} : ir_sr;
      id_sr <= !sel_id ? id_sr : state == CAP_DR ? IDCODE_VAL : state == SHIFT_DR ? {TDI, id_sr[31:1]} : id_sr;
      bsr_sr <= !sel_bsr ? bsr_sr : state == CAP_DR ? {PIN_IN_1, PIN_IN_2, CORE_IN_1, CORE_IN_2} : state == SHIFT_DR ? {TDI, bsr_sr[3:1]} : bsr_sr;
      bp_sr <= !sel_bp ? bp_sr : state == CAP_DR ? 1'b0 : state == SHIFT_DR ? TDI : bp_sr;
    end

  // Falling-edge updates: active IR, BSR update latch and registered TDO
  always_ff @(negedge TCK or posedge TRST)
    if (TRST) begin
      ir <= OP_IDCODE;
      upd <= '0;
      TDO <= 1'b0;
    end else begin
      ir <= state == UPD_IR ? ir_sr : state == TLR ? OP_IDCODE : ir;
      upd <= state == UPD_DR && sel_bsr ? bsr_sr : upd;
      TDO <= state == SHIFT_IR ? ir_sr[0] : state == SHIFT_DR ? dr_bit : 1'b0;
    end

  // Boundary muxes between core and pins
  always_comb begin
    PIN_OUT_1 = drive_pins ? upd[1] : CORE_IN_1;
    PIN_OUT_2 = drive_pins ? upd[0] : CORE_IN_2;
    CORE_OUT_1 = drive_core ? upd[3] : PIN_IN_1;
    CORE_OUT_2 = drive_core ? upd[2] : PIN_IN_2;
  end
endmodule

// File: tb/tb_main_module.sv
// tb_main_module: directed JTAG TAP vectors with hand-computed expectations
module tb_main_module;
  logic TCK = 1'b0, TRST = 1'b0, TMS = 1'b1, TDI = 1'b0, BIST_CLK = 1'b0;
  logic CORE_IN_1 = 1'b0, CORE_IN_2 = 1'b0, PIN_IN_1 = 1'b0, PIN_IN_2 = 1'b0;
  logic CORE_OUT_1, CORE_OUT_2, PIN_OUT_1, PIN_OUT_2, TDO;
  int vectors = 0, miscompares = 0;
  logic [63:0] out;

  main_module dut (
    .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .BIST_CLK(BIST_CLK),
    .CORE_IN_1(CORE_IN_1), .CORE_IN_2(CORE_IN_2), .PIN_IN_1(PIN_IN_1), .PIN_IN_2(PIN_IN_2),
    .CORE_OUT_1(CORE_OUT_1), .CORE_OUT_2(CORE_OUT_2), .PIN_OUT_1(PIN_OUT_1), .PIN_OUT_2(PIN_OUT_2),
    .TDO(TDO)
  );

  always #5 TCK = ~TCK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic m, input logic d);
    TMS = m;
    TDI = d;
    @(posedge TCK);
    @(negedge TCK);
    #1;
  endtask

  task automatic shift(input logic [63:0] data, input int n, output logic [63:0] o);
    o = '0;
    o[0] = TDO;
    for (int i = 0; i < n; i++) begin
      tick(i == n - 1, data[i]);
      if (i < n - 1) o[i+1] = TDO;
    end
  endtask

  task automatic load_ir(input logic [3:0] code, output logic [63:0] o);
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    shift({60'b0, code}, 4, o);
    tick(1, 0);
  endtask

  task automatic dr_scan(input logic [63:0] data, input int n, output logic [63:0] o);
    tick(1, 0); tick(0, 0); tick(0, 0);
    shift(data, n, o);
  endtask

  task automatic read_id(input string tag);
    logic [63:0] o;
    dr_scan(64'h0, 32, o);
    chk(tag, {32'b0, o[31:0]}, 64'h1234_5679);
    tick(1, 0); tick(0, 0);
  endtask

  initial begin
    #1 TRST = 1'b1;
    CORE_IN_1 = 1; CORE_IN_2 = 0; PIN_IN_1 = 0; PIN_IN_2 = 1;
    #10;
    chk("reset_tdo", 64'(TDO), 64'h0);
    chk("reset_pin_out_a", 64'({PIN_OUT_1, PIN_OUT_2}), 64'h2);
    chk("reset_core_out_a", 64'({CORE_OUT_1, CORE_OUT_2}), 64'h1);
    CORE_IN_1 = 0; CORE_IN_2 = 1; PIN_IN_1 = 1; PIN_IN_2 = 0;
    #1;
    chk("reset_pin_out_b", 64'({PIN_OUT_1, PIN_OUT_2}), 64'h1);
    chk("reset_core_out_b", 64'({CORE_OUT_1, CORE_OUT_2}), 64'h2);
    TRST = 1'b0;
    @(negedge TCK); #1;
    tick(0, 0);
    read_id("idcode_after_reset");
    // EXTEST
    CORE_IN_1 = 1; CORE_IN_2 = 1; PIN_IN_1 = 1; PIN_IN_2 = 0;
    load_ir(4'h4, out);
    chk("ir_capture_first2", 64'(out[1:0]), 64'h1);
    chk("ir_capture_all", 64'(out[3:0]), 64'h1);
    chk("extest_pin_at_updir", 64'({PIN_OUT_1, PIN_OUT_2}), 64'h0);
    chk("extest_core_at_updir", 64'({CORE_OUT_1, CORE_OUT_2}), 64'h2);
    tick(0, 0);
    CORE_IN_1 = 0; CORE_IN_2 = 0;
    dr_scan(64'h1E00, 13, out);
    chk("extest_tdo_13", 64'(out[12:0]), 64'h0008);
    chk("extest_pin_hold_exit1", 64'({PIN_OUT_1, PIN_OUT_2}), 64'h0);
    tick(1, 0);
    chk("extest_pin_after_upd", 64'({PIN_OUT_1, PIN_OUT_2}), 64'h3);
    chk("extest_core_after_upd", 64'({CORE_OUT_1, CORE_OUT_2}), 64'h2);
    tick(0, 0);
    PIN_IN_1 = 0; PIN_IN_2 = 1;
    #1;
    chk("extest_core_tracks", 64'({CORE_OUT_1, CORE_OUT_2}), 64'h1);
    // TMS-driven test-logic reset
    for (int i = 0; i < 5; i++) tick(1, 0);
    CORE_IN_1 = 1; CORE_IN_2 = 0;
    #1;
    chk("tlr_normal_pin", 64'({PIN_OUT_1, PIN_OUT_2}), 64'h2);
    tick(0, 0);
    read_id("idcode_after_tlr");
    CORE_IN_1 = 0; CORE_IN_2 = 0;
    load_ir(4'h4, out);
    chk("tlr_keeps_latch", 64'({PIN_OUT_1, PIN_OUT_2}), 64'h3);
    tick(0, 0);
    // BYPASS
    CORE_IN_1 = 1; CORE_IN_2 = 0;
    load_ir(4'hF, out);
    chk("bypass_normal_at_updir", 64'({PIN_OUT_1, PIN_OUT_2}), 64'h2);
    tick(0, 0);
    dr_scan(64'b01101, 5, out);
    chk("bypass_tdo", 64'(out[4:0]), 64'h1A);
    tick(1, 0); tick(0, 0);
    load_ir(4'h3, out);
    tick(0, 0);
    dr_scan(64'b011, 3, out);
    chk("code3_bypass_tdo", 64'(out[2:0]), 64'h6);
    tick(1, 0); tick(0, 0);
    // INTEST
    PIN_IN_1 = 0; PIN_IN_2 = 0; CORE_IN_1 = 0; CORE_IN_2 = 0;
    load_ir(4'h8, out);
    chk("intest_core_at_updir", 64'({CORE_OUT_1, CORE_OUT_2}), 64'h3);
    tick(0, 0);
    PIN_IN_1 = 1; PIN_IN_2 = 1;
    dr_scan(64'h0, 4, out);
    chk("intest_tdo", 64'(out[3:0]), 64'hC);
    tick(1, 0);
    chk("intest_core_after_upd", 64'({CORE_OUT_1, CORE_OUT_2}), 64'h0);
    chk("intest_pin_after_upd", 64'({PIN_OUT_1, PIN_OUT_2}), 64'h0);
    tick(0, 0);
    // Pause holds the shift stage, then reset mid-shift
    CORE_IN_1 = 0; CORE_IN_2 = 1;
    tick(1, 0); tick(0, 0); tick(0, 0);
    chk("pause_cap_bit0", 64'(TDO), 64'h1);
    tick(0, 0);
    chk("pause_bit1", 64'(TDO), 64'h0);
    tick(1, 0); tick(0, 0); tick(0, 0); tick(1, 0); tick(0, 0);
    chk("pause_hold_bit", 64'(TDO), 64'h1);
    #2 TRST = 1'b1;
    #1;
    chk("midshift_reset_tdo", 64'(TDO), 64'h0);
    chk("midshift_reset_core", 64'({CORE_OUT_1, CORE_OUT_2}), 64'h3);
    chk("midshift_reset_pin", 64'({PIN_OUT_1, PIN_OUT_2}), 64'h1);
    #1 TRST = 1'b0;
    @(negedge TCK); #1;
    tick(0, 0);
    read_id("idcode_after_midshift_reset");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
